sram_like_slave: RTL

//  Responder end of the SRAM-like req/addr_ok/data_ok bus driven by the CPU's inst/data ports.

---
 rtl/sram_like_slave.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sram_like_slave.sv
// -----------------------------------------------------------------------------
// sram_like_slave
//
// Responder end of the SRAM-like req/addr_ok/data_ok bus. Requests are served
// from a word-addressed internal memory and answered in accept order exactly
// LATENCY cycles after the accepting handshake. At most MAX_OUTSTANDING
// requests may be accepted but not yet answered.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous, active-high
//   req      in   1   master request valid
//   wr       in   1   1 = write, 0 = read
//   size     in   2   transfer size (informational; wstrb decides the bytes)
//   addr     in   32  byte address; word index = addr[ADDR_W+1:2]
//   wstrb    in   4   byte write enables (writes only)
//   wdata    in   32  write data
//   stall    in   1   test backpressure, forces addr_ok low
//   addr_ok  out  1   request accepted this cycle (combinational)
//   data_ok  out  1   one-cycle response pulse (registered)
//   rdata    out  32  read data, zero unless data_ok of a read
// -----------------------------------------------------------------------------
module sram_like_slave #(
    parameter int ADDR_W          = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]       mem_r [DEPTH];
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              stage_valid_r [LATENCY];
    logic [31:0]       stage_data_r  [LATENCY];
    logic              handshake_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic              unused_s;

    assign handshake_s = req & addr_ok;
    assign word_idx_s  = addr[ADDR_W+1:2];

    // Size and the ignored address bits are deliberately not used.
    assign unused_s = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    // Responses leave straight from the last pipeline stage, so both outputs
    // are flop outputs. Stage data is already zero for writes and bubbles.
    assign data_ok = stage_valid_r[LATENCY-1];
    assign rdata   = stage_data_r[LATENCY-1];

    // Accept when below the cap, or at the cap while a response is retiring
    // this cycle (data_ok is registered, so this is loop-free).
    always_comb begin
        addr_ok = 1'b0;
        if (req && !stall && ((cnt_r < CNT_MAX) || data_ok)) begin
            addr_ok = 1'b1;
        end else begin
            addr_ok = 1'b0;
        end
    end

    // In-flight counter next value: accept and retire in one cycle cancel out.
    always_comb begin
        cnt_next_s = cnt_r;
        case ({handshake_s, data_ok})
            2'b10:   cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_next_s = cnt_r;
        endcase
    end

    // In-flight counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // Response delay line; reads capture memory at their handshake edge so the
    // data travels with the request. Reset drops every pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_valid_r[k] <= 1'b0;
                stage_data_r[k]  <= 32'h0000_0000;
            end
        end else begin
            stage_valid_r[0] <= handshake_s;
            stage_data_r[0]  <= (handshake_s && !wr) ? mem_r[word_idx_s] : 32'h0000_0000;
            for (int k = 1; k < LATENCY; k++) begin
                stage_valid_r[k] <= stage_valid_r[k-1];
                stage_data_r[k]  <= stage_data_r[k-1];
            end
        end
    end

    // Byte-masked memory write at the handshake edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (handshake_s && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
